// File: rtl/fetch_pkg.sv
// Package for the instruction-fetch stage.
// Shared widths, the PC increment, the fetch-slot record type and the filler
// instruction word that is presented while no instruction is valid.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One fetch-buffer slot: the fetch address, the returned word, and
    // whether memory has answered yet.
    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } fetch_entry_t;

    // Width of a counter that must be able to hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-slot in-order ring of outstanding and returned fetches.
// A slot is allocated at the tail when a request is granted, filled at the
// oldest unfilled slot when its response arrives, and popped at the head once
// the consumer takes it. flush discards everything in one cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all slots (redirect)
//   alloc, alloc_pc   allocate tail slot for a granted fetch of alloc_pc
//   fill, fill_instr  write the oldest unfilled slot with a returned word
//   pop               release the head slot
//   head_filled       head slot holds a returned word
//   head_pc/instr     head contents, zero while head_filled is low
//   alloc_cnt         slots currently allocated (filled or not)
//   pend_cnt          allocated slots still waiting for their response
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc,
    input  logic [WIDTH-1:0] alloc_pc,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_instr,
    input  logic             pop,
    output logic             head_filled,
    output logic [WIDTH-1:0] head_pc,
    output logic [WIDTH-1:0] head_instr,
    output logic [CW-1:0]    alloc_cnt,
    output logic [CW-1:0]    pend_cnt
);

    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    fill_ptr_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    alloc_cnt_reg;
    logic [CW-1:0]    pend_cnt_reg;

    logic [WIDTH-1:0] pc_arr    [DEPTH];
    logic [WIDTH-1:0] instr_arr [DEPTH];
    logic [DEPTH-1:0] filled_vec;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [WIDTH-1:0] pc_reg;
            logic [WIDTH-1:0] instr_reg;
            logic             filled_reg;
            logic             hit_alloc;
            logic             hit_fill;
            logic             hit_pop;

            assign hit_alloc = alloc && (tail_reg == PW'(gi));
            assign hit_fill  = fill && (fill_ptr_reg == PW'(gi));
            assign hit_pop   = pop && (head_reg == PW'(gi));

            // Payload needs no reset: it is only observed once filled is set.
            always_ff @(posedge clk) begin
                if (hit_alloc) pc_reg <= alloc_pc;
                if (hit_fill)  instr_reg <= fill_instr;
            end

            always_ff @(posedge clk) begin
                if (rst || flush)             filled_reg <= 1'b0;
                else if (hit_fill)            filled_reg <= 1'b1;
                else if (hit_pop || hit_alloc) filled_reg <= 1'b0;
            end

            assign pc_arr[gi]     = pc_reg;
            assign instr_arr[gi]  = instr_reg;
            assign filled_vec[gi] = filled_reg;
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg      <= '0;
            fill_ptr_reg  <= '0;
            tail_reg      <= '0;
            alloc_cnt_reg <= '0;
            pend_cnt_reg  <= '0;
        end else begin
            if (alloc) tail_reg     <= tail_reg + PW'(1);
            if (fill)  fill_ptr_reg <= fill_ptr_reg + PW'(1);
            if (pop)   head_reg     <= head_reg + PW'(1);
            alloc_cnt_reg <= alloc_cnt_reg + CW'(alloc) - CW'(pop);
            pend_cnt_reg  <= pend_cnt_reg + CW'(alloc) - CW'(fill);
        end
    end

    assign head_filled = filled_vec[head_reg];
    assign head_pc     = head_filled ? pc_arr[head_reg] : '0;
    assign head_instr  = head_filled ? instr_arr[head_reg] : WIDTH'(NOP_INSTR);
    assign alloc_cnt   = alloc_cnt_reg;
    assign pend_cnt    = pend_cnt_reg;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage.
// Owns the PC, issues in-order word reads to instruction memory, buffers the
// returned words with their PC and presents {out_pc, out_instr} to IF/ID over
// valid/ready. A redirect reloads the PC, clears the buffer and arranges for
// every response still in flight to be discarded.
// Optional build macro: FETCH_STATS_EN adds stat_instr (accepted instructions)
// and stat_redirect (redirect cycles) counters.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req/addr/gnt            request channel (issued when req & gnt)
//   imem_rvalid/rdata            in-order response channel
//   redirect_valid/redirect_pc   branch/jump/exception redirect
//   out_valid/ready/pc/instr     handshake toward IF/ID
//   stat_instr, stat_redirect    counters (FETCH_STATS_EN only)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr
`ifdef FETCH_STATS_EN
    ,
    output logic [WIDTH-1:0] stat_instr,
    output logic [WIDTH-1:0] stat_redirect
`endif
);

    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] pc_reg;
    logic [CW-1:0]    drop_cnt_reg;
    logic [CW-1:0]    drop_cnt_next;
    logic [CW-1:0]    alloc_cnt;
    logic [CW-1:0]    pend_cnt;
    logic [CW:0]      occupancy;
    logic [CW:0]      inflight;
    logic             issue;
    logic             fill;
    logic             pop;
    logic             head_filled;
    logic             unused_align;

    // Low address bits of a redirect target are forced to word alignment.
    assign unused_align = ^redirect_pc[1:0];

    // Responses that will be discarded still occupy capacity, so they count
    // against DEPTH together with the allocated slots.
    assign occupancy = {1'b0, alloc_cnt} + {1'b0, drop_cnt_reg};
    assign inflight  = {1'b0, pend_cnt} + {1'b0, drop_cnt_reg};

    assign imem_req  = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = pc_reg;
    assign issue     = imem_req && imem_gnt;

    // A response with nothing outstanding is ignored entirely.
    assign fill = imem_rvalid && !rst && !redirect_valid
                  && (drop_cnt_reg == '0) && (pend_cnt != '0);

    assign out_valid = head_filled;
    assign pop       = head_filled && out_ready && !rst && !redirect_valid;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (redirect_valid) begin
            // Everything still outstanding after this cycle must be dropped;
            // a response arriving in the redirect cycle itself is consumed now.
            if (imem_rvalid && (inflight != '0))
                drop_cnt_next = CW'(inflight - (CW+1)'(1));
            else
                drop_cnt_next = CW'(inflight);
        end else if (imem_rvalid && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            drop_cnt_reg <= '0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
            if (redirect_valid)
                pc_reg <= {redirect_pc[WIDTH-1:2], 2'b00};
            else if (issue)
                pc_reg <= pc_reg + WIDTH'(PC_STEP);
        end
    end

    fetch_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect_valid),
        .alloc       (issue),
        .alloc_pc    (pc_reg),
        .fill        (fill),
        .fill_instr  (imem_rdata),
        .pop         (pop),
        .head_filled (head_filled),
        .head_pc     (out_pc),
        .head_instr  (out_instr),
        .alloc_cnt   (alloc_cnt),
        .pend_cnt    (pend_cnt)
    );

`ifdef FETCH_STATS_EN
    logic [WIDTH-1:0] stat_instr_reg;
    logic [WIDTH-1:0] stat_redirect_reg;

    // A handshake in a redirect cycle still delivered its instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_instr_reg    <= '0;
            stat_redirect_reg <= '0;
        end else begin
            if (out_valid && out_ready) stat_instr_reg <= stat_instr_reg + WIDTH'(1);
            if (redirect_valid)         stat_redirect_reg <= stat_redirect_reg + WIDTH'(1);
        end
    end

    assign stat_instr    = stat_instr_reg;
    assign stat_redirect = stat_redirect_reg;
`endif

endmodule
